noc_merge_arbiter: RTL and testbench

NOC_MERGE_ARBITER -- requirements
Module: noc_merge_arbiter

---
 rtl/noc_merge_arbiter_pkg.sv | 14 +
 rtl/noc_merge_arbiter_rr_arb2.sv | 20 ++
 rtl/noc_merge_arbiter.sv | 101 ++++++++++
 tb/tb_noc_merge_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_merge_arbiter_pkg.sv
// Shared NoC definitions: default packet width, address field position and
// the output-register state encoding used by the merge arbiter.
package noc_merge_arbiter_pkg;

  localparam int NOC_W    = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/noc_merge_arbiter_rr_arb2.sv
// Two-way grant selection: a lone requester wins outright, and a tie is
// settled by the priority pointer. The grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // grant decode from the request pair and the tie-break pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/noc_merge_arbiter.sv
// Merges two valid/ready packet streams into one registered output stage,
// alternating priority on contention and counting accepted packets per input.
module noc_merge_arbiter
  import noc_merge_arbiter_pkg::*;
#(
  parameter int W  = NOC_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in0_valid,
  input  logic [W-1:0]  in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [W-1:0]  in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          out_src,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  out_state_e    state_r;
  logic          ptr_r;
  logic [W-1:0]  out_data_r;
  logic          out_src_r;
  logic [CW-1:0] cnt0_r;
  logic [CW-1:0] cnt1_r;

  logic [1:0]    gnt_s;
  logic          take_s;
  logic          in0_ready_s;
  logic          in1_ready_s;
  logic          acc0_s;
  logic          acc1_s;
  logic [W-1:0]  sel_data_s;
  logic          sel_src_s;

  rr_arb2 u_arb (
    .req ({in1_valid, in0_valid}),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  // accept path: the output register can load when empty or when it is draining
  always_comb begin
    take_s      = (state_r == EMPTY) || out_ready;
    in0_ready_s = take_s && gnt_s[0] && !reset;
    in1_ready_s = take_s && gnt_s[1] && !reset;
    acc0_s      = in0_valid && in0_ready_s;
    acc1_s      = in1_valid && in1_ready_s;
    if (acc1_s) begin
      sel_data_s = in1_data;
      sel_src_s  = 1'b1;
    end else begin
      sel_data_s = in0_data;
      sel_src_s  = 1'b0;
    end
  end

  // output register, priority pointer and saturating acceptance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= EMPTY;
      ptr_r      <= 1'b0;
      out_data_r <= {W{1'b0}};
      out_src_r  <= 1'b0;
      cnt0_r     <= {CW{1'b0}};
      cnt1_r     <= {CW{1'b0}};
    end else begin
      if (acc0_s || acc1_s) begin
        state_r    <= FULL;
        out_data_r <= sel_data_s;
        out_src_r  <= sel_src_s;
        ptr_r      <= ~sel_src_s;
      end else if (out_ready) begin
        state_r    <= EMPTY;
      end
      if (acc0_s && (cnt0_r != CNT_MAX)) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end
      if (acc1_s && (cnt1_r != CNT_MAX)) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign in0_ready = in0_ready_s;
  assign in1_ready = in1_ready_s;
  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign cnt0      = cnt0_r;
  assign cnt1      = cnt1_r;

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Self-checking bench for noc_merge_arbiter: directed scenarios plus a random
// run, all compared against a queue-based model of the merge behaviour.
module tb_noc_merge_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [8:0] in0_data = 9'h000, in1_data = 9'h000;

  logic       in0_ready, in1_ready, out_valid, out_src;
  logic [8:0] out_data;
  logic [7:0] cnt0, cnt1;

  logic       in0_ready_s, in1_ready_s, out_valid_s, out_src_s;
  logic [8:0] out_data_s;
  logic [1:0] cnt0_s, cnt1_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed { logic [8:0] data; logic src; } pkt_t;
  pkt_t sb_q[$];
  int   m_next = 0;
  int   n0 = 0, n1 = 0;
  bit   exp_r0, exp_r1, obs_r0, obs_r1;

  noc_merge_arbiter #(.W(9), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_src(out_src), .cnt0(cnt0), .cnt1(cnt1)
  );

  noc_merge_arbiter #(.W(9), .CW(2)) dut_s (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready_s),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
    .out_src(out_src_s), .cnt0(cnt0_s), .cnt1(cnt1_s)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  // One clock: predict grants from the model, sample readies, advance the model.
  task automatic step();
    int win;
    bit take;
    @(negedge clk);
    take = (sb_q.size() == 0) || out_ready;
    win  = -1;
    if (!reset && take) begin
      if (in0_valid && in1_valid) win = m_next;
      else if (in0_valid)         win = 0;
      else if (in1_valid)         win = 1;
    end
    exp_r0 = (win == 0);
    exp_r1 = (win == 1);
    obs_r0 = in0_ready;
    obs_r1 = in1_ready;
    @(posedge clk);
    if (reset) begin
      sb_q.delete();
      m_next = 0; n0 = 0; n1 = 0;
    end else begin
      if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (win == 0) begin
        sb_q.push_back('{data: in0_data, src: 1'b0}); m_next = 1; n0++;
      end else if (win == 1) begin
        sb_q.push_back('{data: in1_data, src: 1'b1}); m_next = 0; n1++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    in0_data = 9'h1FF; in1_data = 9'h0AB;
    step();
    total_cnt++; if ({obs_r0, obs_r1} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {obs_r0, obs_r1}); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 9'h000) $display("FAIL rst_data: got %h want 000", out_data); else pass_cnt++;
    total_cnt++; if (out_src !== 1'b0) $display("FAIL rst_src: got %b want 0", out_src); else pass_cnt++;
    total_cnt++; if ({cnt0, cnt1} !== 16'h0000) $display("FAIL rst_cnt: got %h/%h want 0/0", cnt0, cnt1); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1; in0_data = 9'h101 + 9'(i);
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 9'h101 + 9'(i) || out_src !== 1'b0)
        $display("FAIL single_out[%0d]: got v=%b d=%h s=%b want v=1 d=%h s=0", i, out_valid, out_data, out_src, 9'h101 + 9'(i));
      else pass_cnt++;
    end
    in0_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd4 || cnt1 !== 8'd0) $display("FAIL single_cnt: got %0d/%0d want 4/0", cnt0, cnt1); else pass_cnt++;
    total_cnt++; if (cnt0_s !== 2'd3) $display("FAIL single_cnt_sat: got %0d want 3", cnt0_s); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [8:0] exp_d [4];
    logic       exp_s [4];
    exp_d = '{9'h1A5, 9'h0F3, 9'h1A5, 9'h0F3};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 9'h1A5; in1_data = 9'h0F3;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (obs_r0 !== ~exp_s[i] || obs_r1 !== exp_s[i])
        $display("FAIL cont_ready[%0d]: got %b%b want %b%b", i, obs_r1, obs_r0, exp_s[i], ~exp_s[i]);
      else pass_cnt++;
      total_cnt++; if (out_data !== exp_d[i] || out_src !== exp_s[i])
        $display("FAIL cont_out[%0d]: got d=%h s=%b want d=%h s=%b", i, out_data, out_src, exp_d[i], exp_s[i]);
      else pass_cnt++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in0_valid = 1'b1; in0_data = 9'h155;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 9'h155) $display("FAIL bp_load: got v=%b d=%h want v=1 d=155", out_valid, out_data); else pass_cnt++;
    in1_valid = 1'b1; in0_data = 9'h0AA; in1_data = 9'h133;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++; if ({obs_r1, obs_r0} !== 2'b00) $display("FAIL bp_ready[%0d]: got %b%b want 00", i, obs_r1, obs_r0); else pass_cnt++;
      total_cnt++; if (out_data !== 9'h155 || out_src !== 1'b0) $display("FAIL bp_hold[%0d]: got d=%h s=%b want d=155 s=0", i, out_data, out_src); else pass_cnt++;
    end
    out_ready = 1'b1;
    step();
    total_cnt++; if ({obs_r1, obs_r0} !== 2'b10) $display("FAIL bp_release_ready: got %b%b want 10", obs_r1, obs_r0); else pass_cnt++;
    total_cnt++; if (out_data !== 9'h133 || out_src !== 1'b1) $display("FAIL bp_release_out: got d=%h s=%b want d=133 s=1", out_data, out_src); else pass_cnt++;
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in1_valid = 1'b1; in1_data = 9'h0C0 + 9'(i);
      step();
      total_cnt++; if (out_data_s !== 9'h0C0 + 9'(i) || out_src_s !== 1'b1)
        $display("FAIL sat_fwd[%0d]: got d=%h s=%b want d=%h s=1", i, out_data_s, out_src_s, 9'h0C0 + 9'(i));
      else pass_cnt++;
    end
    in1_valid = 1'b0;
    step();
    total_cnt++; if (cnt1_s !== 2'd3) $display("FAIL sat_cnt1: got %0d want 3", cnt1_s); else pass_cnt++;
    total_cnt++; if (cnt1 !== 8'd6) $display("FAIL sat_cnt1_wide: got %0d want 6", cnt1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in0_valid = 1'b1; in0_data = 9'h1E1;
    step();
    in0_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) $display("FAIL midrst_cnt: got %0d/%0d want 0/0", cnt0, cnt1); else pass_cnt++;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 9'h011; in1_data = 9'h022;
    step();
    total_cnt++; if ({obs_r1, obs_r0} !== 2'b01 || out_src !== 1'b0) $display("FAIL midrst_ptr: got r=%b%b s=%b want r=01 s=0", obs_r1, obs_r0, out_src); else pass_cnt++;
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_idle_drain();
    do_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in0_data = 9'h077;
    step();
    in0_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", out_valid); else pass_cnt++;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 9'h078; in1_data = 9'h179;
    step();
    total_cnt++; if (out_data !== 9'h179 || out_src !== 1'b1) $display("FAIL drain_ptr: got d=%h s=%b want d=179 s=1", out_data, out_src); else pass_cnt++;
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_random();
    bit exp_v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      in0_valid = ($urandom_range(0, 2) != 0);
      in1_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in0_data  = 9'($urandom_range(0, 511));
      in1_data  = 9'($urandom_range(0, 511));
      step();
      exp_v = (sb_q.size() != 0);
      total_cnt++; if ({obs_r1, obs_r0} !== {exp_r1, exp_r0}) $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, obs_r1, obs_r0, exp_r1, exp_r0); else pass_cnt++;
      total_cnt++; if (out_valid !== exp_v) $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_v); else pass_cnt++;
      if (exp_v) begin
        total_cnt++; if (out_data !== sb_q[0].data || out_src !== sb_q[0].src)
          $display("FAIL rnd_out[%0d]: got d=%h s=%b want d=%h s=%b", i, out_data, out_src, sb_q[0].data, sb_q[0].src);
        else pass_cnt++;
      end
      total_cnt++; if (cnt0 !== 8'(sat(n0, 255)) || cnt1 !== 8'(sat(n1, 255)))
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt0, cnt1, sat(n0, 255), sat(n1, 255));
      else pass_cnt++;
      total_cnt++; if (cnt0_s !== 2'(sat(n0, 3)) || cnt1_s !== 2'(sat(n1, 3)))
        $display("FAIL rnd_cnt_sat[%0d]: got %0d/%0d want %0d/%0d", i, cnt0_s, cnt1_s, sat(n0, 3), sat(n1, 3));
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_idle_drain();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
